// File: rtl/uart_pkg.sv
// Shared UART constants and the transmit-scheduler FSM state type.
package uart_pkg;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SEND  = 2'd2
    } state_t;
endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchroniser for a single asynchronous level (tx_busy, RXD).
// Latency: 2 clk edges from input change to q.
// Backpressure: none, free-running.
module uart_bit_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte sources.
// Latency: byte accepted on edge N, tx_start high after N; busy edges seen 2 clk later.
// Backpressure: req_ready only in IDLE with synchronised busy low; one byte per frame.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*BYTE_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [BYTE_W-1:0]          tx_data,
    output logic                       tx_start,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active,
    output logic                       timeout_err
);
    localparam int GW    = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '1;

    state_t            state;
    logic [GW-1:0]     ptr;
    logic [CNT_W-1:0]  cnt;
    logic              busy_s;
    logic              gnt_hit;
    logic              grant_en;
    logic [GW-1:0]     gnt_idx;
    logic [GW-1:0]     cand;
    logic [BYTE_W-1:0] req_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_bytes[g] = req_data[g*BYTE_W +: BYTE_W];
    end

    // Busy resets as asserted so nothing is granted before the real level arrives.
    uart_bit_sync #(.RST_VAL(1'b1)) u_busy_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (tx_busy),
        .q       (busy_s)
    );

    always_comb begin
        gnt_hit = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = GW'((int'(ptr) + i) % NUM_REQ);
            if (!gnt_hit && req_valid[cand]) begin
                gnt_hit = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign grant_en  = (state == ST_IDLE) && !busy_s && gnt_hit;
    assign req_ready = grant_en ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign active    = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            ptr         <= GW'(NUM_REQ - 1);
            cnt         <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_en) begin
                        tx_data  <= req_bytes[gnt_idx];
                        grant_id <= gnt_idx;
                        ptr      <= gnt_idx;
                        cnt      <= '0;
                        tx_start <= 1'b1;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (busy_s) begin
                        tx_start <= 1'b0;
                        state    <= ST_SEND;
                    end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                        cnt         <= cnt + 1'b1;
                        tx_start    <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SEND: begin
                    if (!busy_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: cycle-level reference model plus directed scenarios.
module tb_uart_tx_scheduler;
    localparam int N  = 2;
    localparam int TO = 16;

    logic           clk     = 1'b0;
    logic           reset_n = 1'b1;
    logic           tx_busy = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*8-1:0] req_data  = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic [0:0]     grant_id;
    logic           active;
    logic           timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 waiting for a byte, 1 asking the transmitter, 2 transmitter busy.
    int         m_phase = 0;
    int         m_ptr   = N - 1;
    int         m_cnt   = 0;
    int         m_gid   = 0;
    int         mw;
    logic [7:0] m_data  = 8'h00;
    logic       m_tout  = 1'b0;
    logic       mbs;
    logic [1:0] m_hist  = 2'b11;  // tx_busy as seen 1 and 2 edges ago

    function automatic int winner();
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int w;
        r = '0;
        w = winner();
        if (m_phase == 0 && !m_hist[1] && w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_phase = 0; m_ptr = N - 1; m_cnt = 0; m_data = 8'h00;
                m_gid = 0; m_tout = 1'b0; m_hist = 2'b11;
            end else begin
                mbs    = m_hist[1];
                mw     = winner();
                m_tout = 1'b0;
                case (m_phase)
                    0: if (!mbs && mw >= 0) begin
                        m_data = req_data[mw*8 +: 8];
                        m_gid = mw; m_ptr = mw; m_phase = 1; m_cnt = 0;
                    end
                    1: if (mbs) m_phase = 2;
                       else begin
                           m_cnt++;
                           if (TO != 0 && m_cnt == TO) begin m_tout = 1'b1; m_phase = 0; end
                       end
                    default: if (!mbs) m_phase = 0;
                endcase
                m_hist = {m_hist[0], tx_busy};
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("req_ready",   req_ready,   exp_ready());
            chk("tx_start",    tx_start,    m_phase == 1);
            chk("active",      active,      m_phase != 0);
            chk("timeout_err", timeout_err, m_tout);
            chk("tx_data",     tx_data,     m_data);
            chk("grant_id",    grant_id,    m_gid);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0: return tx_start == 1'b0;
            1: return active == 1'b0;
            2: return timeout_err == 1'b1;
            3: return req_ready != '0;
            default: return tx_start == 1'b1;
        endcase
    endfunction

    // Edges until the condition holds; 999 when the budget runs out.
    task automatic count_edges(input int sel, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!cond(sel) && n < 40);
        if (!cond(sel)) n = 999;
    endtask

    logic [7:0] rec_data[$];
    int         rec_gid[$];

    task automatic run_frame(input bit drop);
        int n;
        count_edges(4, n);
        if (n == 999) chk("frame_start_seen", 0, 1);
        if (drop) req_valid = '0;
        repeat (2) tick();
        tx_busy = 1'b1;
        rec_data.push_back(tx_data);
        rec_gid.push_back(int'(grant_id));
        repeat (5) tick();
        tx_busy = 1'b0;
        count_edges(1, n);
        chk("frame_end_edges", n, 3);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int n;
        int hits;
        #1 reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_active", active, 0);
        chk("rst_timeout_err", timeout_err, 0);
        reset_n = 1'b1;

        // Single requester
        req_data[7:0] = 8'hA5;
        req_valid = 2'b01;
        count_edges(3, n);
        chk("single_ready", req_ready, 2'b01);
        tick();
        chk("single_tx_data", tx_data, 8'hA5);
        chk("single_tx_start", tx_start, 1);
        chk("single_ready_gone", req_ready, 0);
        req_valid = '0;
        repeat (5) tick();
        tx_busy = 1'b1;
        count_edges(0, n);
        chk("busy_rise_to_start_low", n, 3);
        repeat (4) tick();
        tx_busy = 1'b0;
        count_edges(1, n);
        chk("busy_fall_to_idle", n, 3);

        // Contention, both valid continuously
        do_reset();
        req_data = {8'h22, 8'h11};
        req_valid = 2'b11;
        for (int f = 0; f < 4; f++) run_frame(f == 3);
        chk("rr_data0", rec_data[0], 8'h11);
        chk("rr_data1", rec_data[1], 8'h22);
        chk("rr_data2", rec_data[2], 8'h11);
        chk("rr_data3", rec_data[3], 8'h22);
        chk("rr_gid0", rec_gid[0], 0);
        chk("rr_gid1", rec_gid[1], 1);
        chk("rr_gid2", rec_gid[2], 0);
        chk("rr_gid3", rec_gid[3], 1);

        // Timeout with tx_busy held low
        req_valid = 2'b01;
        count_edges(4, n);
        req_valid = '0;
        count_edges(2, n);
        chk("timeout_edges", n, 16);
        chk("timeout_idle", active, 0);
        tick();
        chk("timeout_pulse_width", timeout_err, 0);
        req_valid = 2'b10;
        run_frame(1);
        chk("after_timeout_data", rec_data[4], 8'h22);
        chk("after_timeout_gid", rec_gid[4], 1);

        // Busy high out of reset
        reset_n = 1'b0;
        tx_busy = 1'b1;
        req_valid = 2'b10;
        repeat (2) tick();
        reset_n = 1'b1;
        hits = 0;
        repeat (6) begin
            tick();
            if (req_ready != '0) hits++;
        end
        chk("busy_idle_no_ready", hits, 0);
        tx_busy = 1'b0;
        count_edges(3, n);
        chk("busy_idle_fall_edges", n, 2);
        chk("busy_idle_ready", req_ready, 2'b10);
        run_frame(1);

        // Reset in the middle of SEND
        req_valid = 2'b01;
        count_edges(4, n);
        req_valid = '0;
        tick();
        tx_busy = 1'b1;
        repeat (4) tick();
        chk("send_active", active, 1);
        chk("send_tx_start", tx_start, 0);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_tx_start", tx_start, 0);
        chk("arst_tx_data", tx_data, 8'h00);
        chk("arst_grant_id", grant_id, 0);
        chk("arst_active", active, 0);
        chk("arst_req_ready", req_ready, 0);
        chk("arst_timeout_err", timeout_err, 0);
        tx_busy = 1'b0;
        req_valid = 2'b11;
        tick();
        reset_n = 1'b1;
        count_edges(3, n);
        chk("post_rst_edges", n, 2);
        chk("post_rst_winner", req_ready, 2'b01);
        run_frame(1);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
